// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan controller.
package seg_scan_ctrl_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } slot_e;

    // Clamped $clog2 so single-digit or tiny-divider builds still get a 1-bit counter.
    function automatic int unsigned width_of(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_hex2sev_segm.sv
// Hex nibble to active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}.
module hex2sev_segm
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] segm
);

    always_comb begin
        segm = SEG_BLANK;
        case (hex)
            4'h0: segm = 7'b1000000;
            4'h1: segm = 7'b1111001;
            4'h2: segm = 7'b0100100;
            4'h3: segm = 7'b0110000;
            4'h4: segm = 7'b0011001;
            4'h5: segm = 7'b0010010;
            4'h6: segm = 7'b0000010;
            4'h7: segm = 7'b1111000;
            4'h8: segm = 7'b0000000;
            4'h9: segm = 7'b0010000;
            4'ha: segm = 7'b0001000;
            4'hb: segm = 7'b0000011;
            4'hc: segm = 7'b1000110;
            4'hd: segm = 7'b0100001;
            4'he: segm = 7'b0000110;
            4'hf: segm = 7'b0001110;
            default: segm = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment display,
// with per-slot blanking and frame-synchronised display updates.
module seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned DIV        = 50000,
    parameter int unsigned BLANK_CYC  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_DIGITS-1:0]   dig_en,
    input  logic                    lz_blank,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic [6:0]              segm,
    output logic                    frame_done
);

    import seg_scan_ctrl_pkg::*;

    localparam int unsigned IDX_W = width_of(NUM_DIGITS);
    localparam int unsigned CNT_W = width_of(DIV);
    localparam int unsigned DW    = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    slot_e                 slot_q, slot_d;
    logic [DW-1:0]         disp_q, disp_d;
    logic [DW-1:0]         pend_q, pend_d;
    logic                  pend_full_q, pend_full_d;
    logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
    logic [6:0]            segm_q, segm_d;
    logic                  frame_done_q;

    logic       wrap;
    logic       frame_end;
    logic [3:0] nib;
    logic       tail_zero;
    logic       dark;
    logic [6:0] dec_segm;

    assign wrap      = (cnt_q == CNT_MAX);
    assign frame_end = wrap && (idx_q == IDX_MAX);

    // Prescaler, digit rotation and slot FSM.
    always_comb begin
        cnt_d  = wrap ? '0 : cnt_q + 1'b1;
        idx_d  = idx_q;
        slot_d = slot_q;
        if (wrap) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end
        unique case (slot_q)
            BLANK:   if (cnt_q == BLANK_END) slot_d = DRIVE;
            DRIVE:   if (wrap) slot_d = BLANK;
            default: slot_d = BLANK;
        endcase
    end

    // Single-entry pending buffer; commit and capture are exclusive because
    // in_ready is low whenever the buffer is full.
    always_comb begin
        disp_d      = disp_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        if (frame_end && pend_full_q) begin
            disp_d      = pend_q;
            pend_full_d = 1'b0;
        end else if (in_valid && !pend_full_q) begin
            pend_d      = in_data;
            pend_full_d = 1'b1;
        end
    end

    // Digit mux plus "this digit and everything above it is zero" for leading-zero blanking.
    always_comb begin
        nib       = 4'h0;
        tail_zero = 1'b1;
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (idx_q == IDX_W'(k)) nib = disp_q[4*k +: 4];
            if (IDX_W'(k) >= idx_q && disp_q[4*k +: 4] != 4'h0) tail_zero = 1'b0;
        end
    end

    assign dark = !dig_en[idx_q] || (lz_blank && (idx_q != '0) && tail_zero);

    hex2sev_segm u_dec (
        .hex  (nib),
        .segm (dec_segm)
    );

    always_comb begin
        an_n_d = '1;
        segm_d = SEG_BLANK;
        if (slot_q == DRIVE && !dark) begin
            an_n_d[idx_q] = 1'b0;
            segm_d        = dec_segm;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            slot_q       <= BLANK;
            disp_q       <= '0;
            pend_q       <= '0;
            pend_full_q  <= 1'b0;
            an_n_q       <= '1;
            segm_q       <= SEG_BLANK;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            slot_q       <= slot_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_full_q  <= pend_full_d;
            an_n_q       <= an_n_d;
            segm_q       <= segm_d;
            frame_done_q <= frame_end;
        end
    end

    assign in_ready   = ~pend_full_q;
    assign an_n       = an_n_q;
    assign segm       = segm_q;
    assign frame_done = frame_done_q;

endmodule
